// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_ctrl_pkg;

  localparam int REG_AW    = 5;
  localparam int NUM_FWD   = 3;
  localparam int FWD_SEL_W = $clog2(NUM_FWD);

  localparam logic [FWD_SEL_W-1:0] FWD_RF  = 2'd0;
  localparam logic [FWD_SEL_W-1:0] FWD_MEM = 2'd1;
  localparam logic [FWD_SEL_W-1:0] FWD_WB  = 2'd2;

  // One scoreboard slot; rs1/rs2 are zero when the instruction does not read them.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              wen;
    logic              mem_read;
  } sb_slot_t;

  function automatic logic reg_hit(input logic valid, input logic wen,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] idx);
    return valid && wen && (rd != '0) && (rd == idx);
  endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// Selects the EX operand source for one register index: MEM result beats WB data.
module hazard_fwd_match
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0]    src,
  input  logic                 mem_valid,
  input  logic                 mem_wen,
  input  logic [REG_AW-1:0]    mem_rd,
  input  logic                 wb_valid,
  input  logic                 wb_wen,
  input  logic [REG_AW-1:0]    wb_rd,
  output logic [FWD_SEL_W-1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_hit(mem_valid, mem_wen, mem_rd, src)) begin
      sel = FWD_MEM;
    end else if (reg_hit(wb_valid, wb_wen, wb_rd, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipe; EX/MEM/WB scoreboard drives stall, flush, forward.
// Optional HAZARD_PERF_EN adds stall_cycles, flush_count and fwd_count counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wen,
  input  logic              id_mem_read,
  input  logic              ex_br_taken,
  input  logic              mem_busy,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              id_byp_a,
  output logic              id_byp_b,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count,
  output logic [31:0]       fwd_count
`endif
);

  sb_slot_t ex_q, mem_q, wb_q, id_entry;
  logic     run_q;
  logic     busy, flush, load_use;
  logic     unused_slot_bits;

  always_comb begin
    id_entry = '0;
    id_entry.valid = id_valid;
    if (id_valid) begin
      id_entry.rd       = id_rd;
      id_entry.wen      = id_reg_wen;
      id_entry.mem_read = id_mem_read;
      id_entry.rs1      = id_use_rs1 ? id_rs1 : '0;
      id_entry.rs2      = id_use_rs2 ? id_rs2 : '0;
    end
  end

  // run_q keeps every control low during the first cycle after reset.
  assign busy     = mem_busy & run_q;
  assign flush    = ex_br_taken & ex_q.valid;
  assign load_use = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_q.rd)) |
                     (id_use_rs2 & (id_rs2 == ex_q.rd)));

  // Priority: freeze, then flush (squashes the ID instruction), then load-use.
  assign pc_stall     = busy | (load_use & ~flush);
  assign if_id_stall  = busy | (load_use & ~flush);
  assign id_ex_bubble = ~busy & (flush | load_use);
  assign if_id_flush  = ~busy & flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= 1'b0;
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      run_q <= 1'b1;
      if (!busy) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= (flush | load_use) ? sb_slot_t'('0) : id_entry;
      end
    end
  end

  hazard_fwd_match u_fwd_a (
    .src       (ex_q.rs1),
    .mem_valid (mem_q.valid),
    .mem_wen   (mem_q.wen),
    .mem_rd    (mem_q.rd),
    .wb_valid  (wb_q.valid),
    .wb_wen    (wb_q.wen),
    .wb_rd     (wb_q.rd),
    .sel       (fwd_a_sel)
  );

  hazard_fwd_match u_fwd_b (
    .src       (ex_q.rs2),
    .mem_valid (mem_q.valid),
    .mem_wen   (mem_q.wen),
    .mem_rd    (mem_q.rd),
    .wb_valid  (wb_q.valid),
    .wb_wen    (wb_q.wen),
    .wb_rd     (wb_q.rd),
    .sel       (fwd_b_sel)
  );

  // Regfile write and ID read land in the same cycle.
  assign id_byp_a  = reg_hit(wb_q.valid, wb_q.wen, wb_q.rd, id_rs1);
  assign id_byp_b  = reg_hit(wb_q.valid, wb_q.wen, wb_q.rd, id_rs2);
  assign ex_valid  = ex_q.valid;
  assign mem_valid = mem_q.valid;
  assign wb_valid  = wb_q.valid;

  assign unused_slot_bits = ^{ex_q.wen, mem_q.rs1, mem_q.rs2, mem_q.mem_read,
                              wb_q.rs1, wb_q.rs2, wb_q.mem_read};

`ifdef HAZARD_PERF_EN
  logic any_fwd;
  assign any_fwd = (fwd_a_sel != FWD_RF) | (fwd_b_sel != FWD_RF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      fwd_count    <= '0;
    end else begin
      if (pc_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush && flush_count != '1) flush_count <= flush_count + 32'd1;
      if (any_fwd && fwd_count != '1) fwd_count <= fwd_count + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_load_fwd: assert property (@(posedge clk) disable iff (!reset)
    !(mem_q.mem_read && ((fwd_a_sel == FWD_MEM) || (fwd_b_sel == FWD_MEM))));
`endif

endmodule
